sdram_burst_arb: RTL and testbench
==================================

Name: sdram_burst_arb

Overview:
- Upstream command source for the SDRAM command sequencer.
- Watches write-FIFO and read-FIFO fill levels and arbitrates between burst-write and burst-read requests.
- Drives ctrl_cmd/sys_addr to the sequencer and holds them stable until cmd_ack.
- Keeps independent auto-incrementing, wrapping write and read address pointers.

Parameters:
- ADDR_W, 22, sys_addr width: bank[21:20], row[19:8], col[7:0]
- LVL_W, 9, width of FIFO level inputs
- BURST_LEN, 4, words per burst; must match the mode-register burst length
- RFIFO_DEPTH, 256, read FIFO capacity in words
- WDOG_CYCLES, 64, ack timeout in cycles (watchdog build only)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- sdram_init_done  in  1  sequencer init complete
- wr_en  in  1  allow write bursts
- rd_en  in  1  allow read bursts
- wfifo_level  in  LVL_W  words available in the write FIFO
- rfifo_level  in  LVL_W  words occupied in the read FIFO
- wr_base, wr_end  in  ADDR_W  write region; wr_end is exclusive
- rd_base, rd_end  in  ADDR_W  read region; rd_end is exclusive
- wr_load  in  1  load wr_addr from wr_base
- rd_load  in  1  load rd_addr from rd_base
- cmd_ack  in  1  one-cycle burst-done pulse from the sequencer
- ctrl_cmd  out  2  00 idle, 01 write burst, 10 read burst
- sys_addr  out  ADDR_W  burst start address
- busy  out  1  burst outstanding
- wr_wrap  out  1  one-cycle pulse when wr_addr wraps
- rd_wrap  out  1  one-cycle pulse when rd_addr wraps
- wdog_err  out  1  sticky timeout flag (watchdog build only; otherwise tied to 0)

Behaviour:
- Reset values: ctrl_cmd=00, sys_addr=0, busy=0, wr_wrap=0, rd_wrap=0, wdog_err=0; wr_addr=0, rd_addr=0; state=IDLE; last_grant=READ, so a write wins first.
- All outputs are registered.
- Readiness:
  - wr_rdy = wr_en & sdram_init_done & (wfifo_level >= BURST_LEN).
  - rd_rdy = rd_en & sdram_init_done & (RFIFO_DEPTH - rfifo_level >= BURST_LEN).
- State machine: IDLE, WR, RD, GAP.
- IDLE:
  - Only wr_rdy → WR; only rd_rdy → RD.
  - Both → the grant opposite to last_grant.
  - On entry, register ctrl_cmd (01 or 10), sys_addr (wr_addr or rd_addr), busy=1, and update last_grant.
- WR/RD:
  - ctrl_cmd and sys_addr are held constant every cycle until cmd_ack.
  - On cmd_ack: ctrl_cmd←00, busy←0, advance the pointer, go to GAP.
- GAP: exactly one cycle, no command, then IDLE. This guarantees ctrl_cmd=00 is seen after the sequencer clears its internal burst flag, so no spurious re-trigger.
- Minimum request-to-request spacing is ack + 2 cycles.
- Pointer advance: next = (addr + BURST_LEN >= end) ? base : addr + BURST_LEN. The wrap case pulses wr_wrap or rd_wrap for one cycle, coincident with GAP.
- wr_load/rd_load apply in any state. Load beats advance when coincident with cmd_ack. A load during WR/RD does not change the held sys_addr.
- Deasserting wr_en/rd_en or dropping a FIFO level mid-burst does not abort; the burst completes.
- cmd_ack in IDLE/GAP is ignored.
- sdram_init_done low: stay in IDLE.
- Refresh interleaving is internal to the sequencer; the arbiter just waits longer for ack.
- Base/end are sampled only at load and at advance. Software keeps end > base and (end - base) a multiple of BURST_LEN.

Optional Feature:
- Macro: SDRAM_ARB_WDOG_EN.
- Defined:
  - A counter runs in WR/RD.
  - Reaching WDOG_CYCLES without cmd_ack → ctrl_cmd←00, busy←0, wdog_err←1 (sticky until rst), go to GAP, pointer not advanced.
- Undefined: no counter; wdog_err tied to 0; WR/RD waits indefinitely.

Decomposition:
- Shared package/header holds:
  - command encodings CMD_IDLE=2'b00, CMD_WR=2'b01, CMD_RD=2'b10
  - state encodings
  - address field positions (bank/row/col slices)
  - default BURST_LEN
- One natural sub-module: sdram_addr_ptr (base/end load, advance, wrap pulse), instantiated twice for write and read.

Test Plan:
- Reset, init_done=1, wr_en=1, wfifo_level=4, wr_base=0, wr_end=0x10 → ctrl_cmd=01, sys_addr=0 held until ack; ack at cycle N → ctrl_cmd=00 at N+1, next write at 0x4.
- Both ready continuously → grants alternate W,R,W,R; first grant is a write; sys_addr alternates between the wr and rd pointers.
- wr_base=0x100, wr_end=0x108, two acked write bursts → sys_addr 0x100, 0x104, then 0x100; wr_wrap pulses once after the second ack.
- rfifo_level=253 with RFIFO_DEPTH=256 → no read issued; drop rfifo_level to 252 → read issued.
- wr_en dropped mid-burst → ctrl_cmd stays 01 until ack; ack coincident with wr_load → pointer = wr_base.
- SDRAM_ARB_WDOG_EN, no ack for 64 cycles → ctrl_cmd=00, wdog_err=1, pointer unchanged; rst clears wdog_err.

Source files
------------

// File: rtl/sdram_burst_arb_pkg.sv
// Shared definitions for the SDRAM burst arbiter: command and state encodings,
// sys_addr field positions and the default burst length.
package sdram_burst_arb_pkg;

    localparam logic [1:0] CMD_IDLE = 2'b00;
    localparam logic [1:0] CMD_WR   = 2'b01;
    localparam logic [1:0] CMD_RD   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WR   = 2'b01,
        ST_RD   = 2'b10,
        ST_GAP  = 2'b11
    } arb_state_t;

    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_RD = 1'b1
    } grant_t;

    localparam int BANK_MSB = 21;
    localparam int BANK_LSB = 20;
    localparam int ROW_MSB  = 19;
    localparam int ROW_LSB  = 8;
    localparam int COL_MSB  = 7;
    localparam int COL_LSB  = 0;

    localparam int DEF_BURST_LEN = 4;

    function automatic logic [1:0] addr_bank(input logic [21:0] addr);
        return addr[BANK_MSB:BANK_LSB];
    endfunction

    function automatic logic [11:0] addr_row(input logic [21:0] addr);
        return addr[ROW_MSB:ROW_LSB];
    endfunction

    function automatic logic [7:0] addr_col(input logic [21:0] addr);
        return addr[COL_MSB:COL_LSB];
    endfunction

endpackage

// File: rtl/sdram_burst_arb_addr_ptr.sv
// Auto-incrementing burst address pointer over a [base, lim) region; wraps to
// base and pulses wrap for one cycle. A load always wins over an advance.
module sdram_addr_ptr
    import sdram_burst_arb_pkg::*;
#(
    parameter int ADDR_W    = 22,
    parameter int BURST_LEN = DEF_BURST_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] lim,
    output logic [ADDR_W-1:0] addr,
    output logic              wrap
);

    logic [ADDR_W-1:0] addr_r;
    logic              wrap_r;
    logic [ADDR_W:0]   sum_s;
    logic              at_end_s;

    // One extra bit so a pointer near the top of the address space cannot alias past lim
    assign sum_s    = {1'b0, addr_r} + (ADDR_W+1)'(BURST_LEN);
    assign at_end_s = (sum_s >= {1'b0, lim});

    // Pointer and wrap-pulse register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r <= {ADDR_W{1'b0}};
            wrap_r <= 1'b0;
        end else if (load) begin
            addr_r <= base;
            wrap_r <= 1'b0;
        end else if (advance) begin
            if (at_end_s) begin
                addr_r <= base;
                wrap_r <= 1'b1;
            end else begin
                addr_r <= sum_s[ADDR_W-1:0];
                wrap_r <= 1'b0;
            end
        end else begin
            wrap_r <= 1'b0;
        end
    end

    assign addr = addr_r;
    assign wrap = wrap_r;

endmodule

// File: rtl/sdram_burst_arb.sv
// Burst-write/burst-read arbiter feeding the SDRAM command sequencer.
// Optional ack watchdog enabled by defining SDRAM_ARB_WDOG_EN.
module sdram_burst_arb
    import sdram_burst_arb_pkg::*;
#(
    parameter int ADDR_W      = 22,
    parameter int LVL_W       = 9,
    parameter int BURST_LEN   = DEF_BURST_LEN,
    parameter int RFIFO_DEPTH = 256,
    parameter int WDOG_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sdram_init_done,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [LVL_W-1:0]  wfifo_level,
    input  logic [LVL_W-1:0]  rfifo_level,
    input  logic [ADDR_W-1:0] wr_base,
    input  logic [ADDR_W-1:0] wr_end,
    input  logic [ADDR_W-1:0] rd_base,
    input  logic [ADDR_W-1:0] rd_end,
    input  logic              wr_load,
    input  logic              rd_load,
    input  logic              cmd_ack,
    output logic [1:0]        ctrl_cmd,
    output logic [ADDR_W-1:0] sys_addr,
    output logic              busy,
    output logic              wr_wrap,
    output logic              rd_wrap,
    output logic              wdog_err
);

    localparam logic [LVL_W:0] WR_MIN_C = (LVL_W+1)'(BURST_LEN);
    localparam logic [LVL_W:0] RD_MAX_C = (LVL_W+1)'(RFIFO_DEPTH - BURST_LEN);

    arb_state_t        state_r, state_nxt_s;
    grant_t            last_grant_r, grant_nxt_s;
    logic [1:0]        ctrl_cmd_r, cmd_nxt_s;
    logic [ADDR_W-1:0] sys_addr_r, addr_nxt_s;
    logic              busy_r, busy_nxt_s;
    logic              wr_rdy_s, rd_rdy_s;
    logic              wr_adv_s, rd_adv_s;
    logic              wdog_to_s;
    logic [ADDR_W-1:0] wr_addr_s, rd_addr_s;

    assign wr_rdy_s = wr_en & sdram_init_done & ({1'b0, wfifo_level} >= WR_MIN_C);
    assign rd_rdy_s = rd_en & sdram_init_done & ({1'b0, rfifo_level} <= RD_MAX_C);

    sdram_addr_ptr #(.ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN)) u_wr_ptr (
        .clk     (clk),
        .rst     (rst),
        .load    (wr_load),
        .advance (wr_adv_s),
        .base    (wr_base),
        .lim     (wr_end),
        .addr    (wr_addr_s),
        .wrap    (wr_wrap)
    );

    sdram_addr_ptr #(.ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN)) u_rd_ptr (
        .clk     (clk),
        .rst     (rst),
        .load    (rd_load),
        .advance (rd_adv_s),
        .base    (rd_base),
        .lim     (rd_end),
        .addr    (rd_addr_s),
        .wrap    (rd_wrap)
    );

`ifdef SDRAM_ARB_WDOG_EN
    localparam int                WDOG_W      = $clog2(WDOG_CYCLES);
    localparam logic [WDOG_W-1:0] WDOG_LAST_C = WDOG_W'(WDOG_CYCLES - 1);

    logic [WDOG_W-1:0] wdog_cnt_r;
    logic              wdog_err_r;
    logic              in_burst_s;

    assign in_burst_s = (state_r == ST_WR) || (state_r == ST_RD);
    assign wdog_to_s  = in_burst_s && (wdog_cnt_r == WDOG_LAST_C);

    // Ack-timeout counter and sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt_r <= {WDOG_W{1'b0}};
            wdog_err_r <= 1'b0;
        end else begin
            if (in_burst_s && !cmd_ack && !wdog_to_s) begin
                wdog_cnt_r <= wdog_cnt_r + WDOG_W'(1);
            end else begin
                wdog_cnt_r <= {WDOG_W{1'b0}};
            end
            if (wdog_to_s && !cmd_ack) begin
                wdog_err_r <= 1'b1;
            end else begin
                wdog_err_r <= wdog_err_r;
            end
        end
    end

    assign wdog_err = wdog_err_r;
`else
    assign wdog_to_s = 1'b0;
    // Constant 0 for any legal WDOG_CYCLES
    assign wdog_err  = (WDOG_CYCLES < 0);
`endif

    // Next-state, grant and registered-output decode
    always_comb begin
        state_nxt_s = state_r;
        grant_nxt_s = last_grant_r;
        cmd_nxt_s   = ctrl_cmd_r;
        addr_nxt_s  = sys_addr_r;
        busy_nxt_s  = busy_r;
        wr_adv_s    = 1'b0;
        rd_adv_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (wr_rdy_s && (!rd_rdy_s || (last_grant_r == GRANT_RD))) begin
                    state_nxt_s = ST_WR;
                    grant_nxt_s = GRANT_WR;
                    cmd_nxt_s   = CMD_WR;
                    addr_nxt_s  = wr_addr_s;
                    busy_nxt_s  = 1'b1;
                end else if (rd_rdy_s) begin
                    state_nxt_s = ST_RD;
                    grant_nxt_s = GRANT_RD;
                    cmd_nxt_s   = CMD_RD;
                    addr_nxt_s  = rd_addr_s;
                    busy_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WR, ST_RD: begin
                if (cmd_ack || wdog_to_s) begin
                    state_nxt_s = ST_GAP;
                    cmd_nxt_s   = CMD_IDLE;
                    busy_nxt_s  = 1'b0;
                    wr_adv_s    = cmd_ack && (state_r == ST_WR);
                    rd_adv_s    = cmd_ack && (state_r == ST_RD);
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_GAP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cmd_nxt_s   = CMD_IDLE;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            last_grant_r <= GRANT_RD;
            ctrl_cmd_r   <= CMD_IDLE;
            sys_addr_r   <= {ADDR_W{1'b0}};
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            last_grant_r <= grant_nxt_s;
            ctrl_cmd_r   <= cmd_nxt_s;
            sys_addr_r   <= addr_nxt_s;
            busy_r       <= busy_nxt_s;
        end
    end

    assign ctrl_cmd = ctrl_cmd_r;
    assign sys_addr = sys_addr_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_sdram_burst_arb.sv
// Randomized bench for sdram_burst_arb against a cycle-level behavioural model.
// Define SDRAM_ARB_WDOG_EN to also exercise the ack watchdog.
module tb_sdram_burst_arb;

    localparam int BL    = 4;
    localparam int DEPTH = 256;
    localparam int WDOG  = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        sdram_init_done, wr_en, rd_en;
    logic [8:0]  wfifo_level, rfifo_level;
    logic [21:0] wr_base, wr_end, rd_base, rd_end;
    logic        wr_load, rd_load, cmd_ack;
    logic [1:0]  ctrl_cmd;
    logic [21:0] sys_addr;
    logic        busy, wr_wrap, rd_wrap, wdog_err;

    sdram_burst_arb dut (
        .clk             (clk),
        .rst             (rst),
        .sdram_init_done (sdram_init_done),
        .wr_en           (wr_en),
        .rd_en           (rd_en),
        .wfifo_level     (wfifo_level),
        .rfifo_level     (rfifo_level),
        .wr_base         (wr_base),
        .wr_end          (wr_end),
        .rd_base         (rd_base),
        .rd_end          (rd_end),
        .wr_load         (wr_load),
        .rd_load         (rd_load),
        .cmd_ack         (cmd_ack),
        .ctrl_cmd        (ctrl_cmd),
        .sys_addr        (sys_addr),
        .busy            (busy),
        .wr_wrap         (wr_wrap),
        .rd_wrap         (rd_wrap),
        .wdog_err        (wdog_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: kind of outstanding burst (0 none, 1 write, 2 read), cooldown after a burst
    int m_kind, m_addr, m_wptr, m_rptr, m_cool, m_wcnt;
    bit m_last_rd, m_wwrap, m_rwrap, m_werr;
    int stall;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_kind = 0; m_addr = 0; m_wptr = 0; m_rptr = 0; m_cool = 0; m_wcnt = 0;
        m_last_rd = 1'b1; m_wwrap = 1'b0; m_rwrap = 1'b0; m_werr = 1'b0;
    endtask

    // Predict the effect of the coming clock edge from the inputs now applied
    task automatic model_edge();
        bit w_rdy, r_rdy, w_adv, r_adv;
        if (rst) begin
            model_reset();
            return;
        end
        w_rdy = wr_en && sdram_init_done && (int'(wfifo_level) >= BL);
        r_rdy = rd_en && sdram_init_done && ((DEPTH - int'(rfifo_level)) >= BL);
        w_adv = 1'b0; r_adv = 1'b0;
        m_wwrap = 1'b0; m_rwrap = 1'b0;
        if (m_kind != 0) begin
            if (cmd_ack) begin
                if (m_kind == 1) w_adv = 1'b1; else r_adv = 1'b1;
                m_kind = 0; m_cool = 1;
`ifdef SDRAM_ARB_WDOG_EN
            end else if (m_wcnt == WDOG - 1) begin
                m_kind = 0; m_cool = 1; m_werr = 1'b1;
`endif
            end else begin
                m_wcnt++;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (w_rdy && (!r_rdy || m_last_rd)) begin
            m_kind = 1; m_addr = m_wptr; m_last_rd = 1'b0; m_wcnt = 0;
        end else if (r_rdy) begin
            m_kind = 2; m_addr = m_rptr; m_last_rd = 1'b1; m_wcnt = 0;
        end
        if (wr_load) m_wptr = int'(wr_base);
        else if (w_adv) begin
            if (m_wptr + BL >= int'(wr_end)) begin m_wptr = int'(wr_base); m_wwrap = 1'b1; end
            else m_wptr = m_wptr + BL;
        end
        if (rd_load) m_rptr = int'(rd_base);
        else if (r_adv) begin
            if (m_rptr + BL >= int'(rd_end)) begin m_rptr = int'(rd_base); m_rwrap = 1'b1; end
            else m_rptr = m_rptr + BL;
        end
    endtask

    task automatic compare_all();
        check_val("ctrl_cmd", 32'(ctrl_cmd), 32'(m_kind));
        check_val("sys_addr", 32'(sys_addr), 32'(m_addr));
        check_val("busy",     32'(busy),     32'(m_kind != 0));
        check_val("wr_wrap",  32'(wr_wrap),  32'(m_wwrap));
        check_val("rd_wrap",  32'(rd_wrap),  32'(m_rwrap));
        check_val("wdog_err", 32'(wdog_err), 32'(m_werr));
    endtask

    task automatic new_regions(input int phase);
        int wb, rb;
        if (phase == 0) begin
            wr_base = 22'h0; wr_end = 22'h10;
        end else if (phase == 1) begin
            wr_base = 22'h100; wr_end = 22'h108;
        end else begin
            wb = BL * $urandom_range(0, 4096);
            wr_base = 22'(wb); wr_end = 22'(wb + BL * $urandom_range(1, 4));
        end
        rb = BL * $urandom_range(0, 4096);
        rd_base = 22'(rb); rd_end = 22'(rb + BL * $urandom_range(1, 4));
        wr_load = 1'b1; rd_load = 1'b1;
    endtask

    task automatic drive_random(input int cyc);
        wr_load = 1'b0; rd_load = 1'b0;
        rst = (cyc >= 3000 && cyc < 3002);
        if (cyc % 400 == 0) begin
            new_regions(cyc / 400);
`ifdef SDRAM_ARB_WDOG_EN
            if (cyc % 800 == 400) stall = 3 * WDOG;
`endif
        end else begin
            wr_load = ($urandom_range(0, 49) == 0);
            rd_load = ($urandom_range(0, 49) == 0);
        end
        sdram_init_done = ($urandom_range(0, 9) != 0);
        wr_en = ($urandom_range(0, 4) != 0);
        rd_en = ($urandom_range(0, 4) != 0);
        case ($urandom_range(0, 3))
            0: wfifo_level = 9'($urandom_range(0, 8));
            default: wfifo_level = 9'($urandom_range(3, 300));
        endcase
        case ($urandom_range(0, 4))
            0: rfifo_level = 9'd253;
            1: rfifo_level = 9'd252;
            2: rfifo_level = 9'($urandom_range(248, 260));
            default: rfifo_level = 9'($urandom_range(0, 300));
        endcase
        if (stall > 0) begin
            stall--;
            cmd_ack = 1'b0;
        end else if (m_kind != 0) begin
            cmd_ack = ($urandom_range(0, 3) == 0);
        end else begin
            cmd_ack = ($urandom_range(0, 9) == 0);
        end
    endtask

    initial begin
        rst = 1'b1; stall = 0;
        sdram_init_done = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        wfifo_level = 9'd0; rfifo_level = 9'd0;
        wr_base = 22'h0; wr_end = 22'h10; rd_base = 22'h0; rd_end = 22'h10;
        wr_load = 1'b0; rd_load = 1'b0; cmd_ack = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        compare_all();
        rst = 1'b0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            drive_random(cyc);
            model_edge();
            @(negedge clk);
            compare_all();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
